// File: rtl/push_debouncer.sv
// push_debouncer: per-channel 2-FF synchronizer, stability-count debouncer,
// press pulse and optional auto-repeat pulse train for raw push switches.
//
// Ports:
//   clk_2MHz  in   system clock, all state on the rising edge
//   reset     in   synchronous reset, active-low
//   s_async   in   [N_CH] raw asynchronous switch lines
//   s_level   out  [N_CH] debounced state, 1 = pressed
//   s_pulse   out  [N_CH] one-cycle pulse per accepted press / repeat
module push_debouncer #(
    parameter int              N_CH            = 5,
    parameter logic            PRESS_LEVEL     = 1'b1,
    parameter int              DEBOUNCE_CYCLES = 40000,
    parameter int              REPEAT_DELAY    = 1000000,
    parameter int              REPEAT_PERIOD   = 200000,
    parameter logic [N_CH-1:0] REPEAT_EN       = {N_CH{1'b0}}
) (
    input  logic            clk_2MHz,
    input  logic            reset,
    input  logic [N_CH-1:0] s_async,
    output logic [N_CH-1:0] s_level,
    output logic [N_CH-1:0] s_pulse
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_REPEAT
    } rpt_state_e;

    logic [N_CH-1:0] press_raw;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] sync1_d, sync1_q;
    logic [N_CH-1:0] sync2_d, sync2_q;
    logic [N_CH-1:0] level_d, level_q;
    logic [N_CH-1:0] pulse_d, pulse_q;

    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [RC_W-1:0]  rc_d    [N_CH];
    logic [RC_W-1:0]  rc_q    [N_CH];
    rpt_state_e       state_d [N_CH];
    rpt_state_e       state_q [N_CH];

    always_comb begin
        press_raw = '0;
        rise      = '0;
        level_d   = level_q;
        pulse_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            press_raw[i] = (s_async[i] == PRESS_LEVEL);
        end
        sync1_d = press_raw;
        sync2_d = sync1_q;

        for (int i = 0; i < N_CH; i++) begin
            // Debounce: count consecutive cycles where the synchronized
            // input disagrees with the accepted level; any agreement
            // restarts the count.
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end

            rise[i]    = level_d[i] & ~level_q[i];
            pulse_d[i] = rise[i];

            state_d[i] = state_q[i];
            rc_d[i]    = rc_q[i];

            // A release (or a disabled channel) forces IDLE in the same
            // cycle, which also swallows a repeat due on that edge.
            if (!REPEAT_EN[i] || !level_d[i]) begin
                state_d[i] = ST_IDLE;
                rc_d[i]    = '0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        if (rise[i]) begin
                            state_d[i] = ST_WAIT_FIRST;
                            rc_d[i]    = '0;
                        end
                    end
                    ST_WAIT_FIRST: begin
                        if (rc_q[i] == DELAY_LAST) begin
                            pulse_d[i] = 1'b1;
                            state_d[i] = ST_REPEAT;
                            rc_d[i]    = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + RC_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rc_q[i] == PERIOD_LAST) begin
                            pulse_d[i] = 1'b1;
                            rc_d[i]    = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + RC_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        rc_d[i]    = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_2MHz) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= '0;
                rc_q[i]    <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                rc_q[i]    <= rc_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign s_level = level_q;
    assign s_pulse = pulse_q;

endmodule

// File: tb/tb_push_debouncer.sv
// Self-checking bench for push_debouncer: table of held-input segments with
// per-edge expected outputs, plus a hand sequence for the auto-repeat train.
module tb_push_debouncer;

    logic       clk_2MHz;
    logic       reset;
    logic [4:0] s_async;
    logic [4:0] s_level;
    logic [4:0] s_pulse;

    int n_checks;
    int n_fail;

    push_debouncer #(
        .N_CH            (5),
        .PRESS_LEVEL     (1'b1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_EN       (5'b00100)
    ) dut (
        .clk_2MHz (clk_2MHz),
        .reset    (reset),
        .s_async  (s_async),
        .s_level  (s_level),
        .s_pulse  (s_pulse)
    );

    initial clk_2MHz = 1'b0;
    always #5 clk_2MHz = ~clk_2MHz;

    // One segment: drive rst/in for n edges; after every edge the outputs
    // must equal lvl/pls.
    typedef struct {
        string      name;
        logic       rst_n;
        logic [4:0] in;
        int         n;
        logic [4:0] lvl;
        logic [4:0] pls;
    } seg_t;

    seg_t segs[$];

    task automatic add(input string name, input logic r, input logic [4:0] in,
                       input int n, input logic [4:0] lvl,
                       input logic [4:0] pls);
        seg_t s;
        s.name  = name;
        s.rst_n = r;
        s.in    = in;
        s.n     = n;
        s.lvl   = lvl;
        s.pls   = pls;
        segs.push_back(s);
    endtask

    task automatic tick(input logic r, input logic [4:0] in);
        reset   = r;
        s_async = in;
        @(posedge clk_2MHz);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %b expected %b",
                     name, idx, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        s_async  = '0;

        // Reset held with all switches pressed, then all pulse together.
        add("rst_hold",     1'b0, 5'b11111,  3, 5'b00000, 5'b00000);
        add("rst_rel_wait", 1'b1, 5'b11111,  5, 5'b00000, 5'b00000);
        add("rst_rel_acc",  1'b1, 5'b11111,  1, 5'b11111, 5'b11111);
        add("rst_rel_hold", 1'b1, 5'b11111,  1, 5'b11111, 5'b00000);
        add("all_rel_wait", 1'b1, 5'b00000,  5, 5'b11111, 5'b00000);
        add("all_rel_done", 1'b1, 5'b00000,  1, 5'b00000, 5'b00000);
        add("idle0",        1'b1, 5'b00000,  3, 5'b00000, 5'b00000);

        // Clean press on ch0 held 30 cycles, no repeat on this channel.
        add("ch0_wait",     1'b1, 5'b00001,  5, 5'b00000, 5'b00000);
        add("ch0_acc",      1'b1, 5'b00001,  1, 5'b00001, 5'b00001);
        add("ch0_hold",     1'b1, 5'b00001, 24, 5'b00001, 5'b00000);
        add("ch0_rel_wait", 1'b1, 5'b00000,  5, 5'b00001, 5'b00000);
        add("ch0_rel_done", 1'b1, 5'b00000,  3, 5'b00000, 5'b00000);

        // Bounce 1,0,1,1,0,1 then steady 1 on ch1.
        add("ch1_b1",       1'b1, 5'b00010,  1, 5'b00000, 5'b00000);
        add("ch1_b0",       1'b1, 5'b00000,  1, 5'b00000, 5'b00000);
        add("ch1_b11",      1'b1, 5'b00010,  2, 5'b00000, 5'b00000);
        add("ch1_b0b",      1'b1, 5'b00000,  1, 5'b00000, 5'b00000);
        add("ch1_steady",   1'b1, 5'b00010,  5, 5'b00000, 5'b00000);
        add("ch1_acc",      1'b1, 5'b00010,  1, 5'b00010, 5'b00010);
        add("ch1_hold",     1'b1, 5'b00010,  2, 5'b00010, 5'b00000);
        add("ch1_rel_wait", 1'b1, 5'b00000,  5, 5'b00010, 5'b00000);
        add("ch1_rel_done", 1'b1, 5'b00000,  3, 5'b00000, 5'b00000);

        // 3-cycle glitch rejected; 4-cycle excursion just accepted.
        add("ch1_glitch3",  1'b1, 5'b00010,  3, 5'b00000, 5'b00000);
        add("ch1_g3_after", 1'b1, 5'b00000,  8, 5'b00000, 5'b00000);
        add("ch1_glitch4",  1'b1, 5'b00010,  4, 5'b00000, 5'b00000);
        add("ch1_g4_wait",  1'b1, 5'b00000,  1, 5'b00000, 5'b00000);
        add("ch1_g4_acc",   1'b1, 5'b00000,  1, 5'b00010, 5'b00010);
        add("ch1_g4_hold",  1'b1, 5'b00000,  3, 5'b00010, 5'b00000);
        add("ch1_g4_rel",   1'b1, 5'b00000,  3, 5'b00000, 5'b00000);

        // ch3+ch4 together, reset while cnt=2, release with inputs high.
        add("ch34_pre",     1'b1, 5'b11000,  4, 5'b00000, 5'b00000);
        add("ch34_rst",     1'b0, 5'b11000,  2, 5'b00000, 5'b00000);
        add("ch34_wait",    1'b1, 5'b11000,  5, 5'b00000, 5'b00000);
        add("ch34_acc",     1'b1, 5'b11000,  1, 5'b11000, 5'b11000);
        add("ch34_hold",    1'b1, 5'b11000,  3, 5'b11000, 5'b00000);
        add("ch34_rel",     1'b1, 5'b00000,  5, 5'b11000, 5'b00000);
        add("ch34_done",    1'b1, 5'b00000,  3, 5'b00000, 5'b00000);

        foreach (segs[s]) begin
            for (int e = 0; e < segs[s].n; e++) begin
                tick(segs[s].rst_n, segs[s].in);
                check({segs[s].name, ".level"}, e, s_level, segs[s].lvl);
                check({segs[s].name, ".pulse"}, e, s_pulse, segs[s].pls);
            end
        end

        // Auto-repeat on ch2: press pulse at T (k=0), repeats at T+10,
        // T+13, ...; release is timed so s_level falls on T+34, an edge
        // that would otherwise have carried a repeat.
        for (int e = 0; e < 5; e++) begin
            tick(1'b1, 5'b00100);
            check("rpt_wait.level", e, s_level, 5'b00000);
            check("rpt_wait.pulse", e, s_pulse, 5'b00000);
        end
        for (int k = 0; k < 46; k++) begin
            logic [4:0] in_v;
            logic [4:0] exp_l;
            logic [4:0] exp_p;
            in_v  = (k < 29) ? 5'b00100 : 5'b00000;
            exp_l = (k < 34) ? 5'b00100 : 5'b00000;
            exp_p = 5'b00000;
            if (k == 0) exp_p = 5'b00100;
            if (k >= 10 && k < 34 && ((k - 10) % 3) == 0) exp_p = 5'b00100;
            tick(1'b1, in_v);
            check("rpt.level", k, s_level, exp_l);
            check("rpt.pulse", k, s_pulse, exp_p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
